fetch_stall_ctrl: RTL and testbench

//  Fetch-side consumer of the decode hazard/stall interface. It owns the PC and IF/ID registers.
//  It obeys the hazard unit's write-enable (hold on load-use) and the EX-stage branch redirect (flush).
//  It fetches from a variable-latency instruction memory over a req/ready handshake.
//  A one-entry buffer absorbs an instruction that returns while decode is stalled.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stall_ctrl_if_id_reg.sv | 38 +++
 rtl/fetch_stall_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants for the PC / IF-ID path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // REQ: request outstanding at pc; HOLD: buffer full, no request;
  // DISCARD: waiting out a fetch made stale by a redirect.
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  // Instruction word injected for bubbles (all zeros).
  localparam int unsigned NOP_INSTR = 0;

  // Sequential fetch stride in bytes.
  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/fetch_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Latency: 1 cycle from write/flush to outputs.
// Backpressure: we=0 holds contents; flush wins over we and inserts a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [ADDR_W-1:0]  pc4In,
  output logic [INSTR_W-1:0] instrQ,
  output logic [ADDR_W-1:0]  pc4Q,
  output logic               validQ
);

  // Flush clears instruction and valid (pc4 is left as-is, it is
  // meaningless without valid); otherwise load a real instruction on we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instrQ <= INSTR_W'(NOP_INSTR);
      pc4Q   <= '0;
      validQ <= 1'b0;
    end else if (flush) begin
      instrQ <= INSTR_W'(NOP_INSTR);
      validQ <= 1'b0;
    end else if (we) begin
      instrQ <= instrIn;
      pc4Q   <= pc4In;
      validQ <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch controller: owns PC, fetch request, one-entry skid buffer and IF/ID.
// Latency: 1 cycle memory transfer -> IF/ID; 1 instr/cycle with ready held high.
// Backpressure: hazard_we_i=0 parks a returning instruction in the buffer and drops req.
module fetch_stall_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hazard_we_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic               if_id_valid_o
);

  fetchState_t        state;
  logic [ADDR_W-1:0]  pcQ;
  logic [ADDR_W-1:0]  addrQ;     // address presented to memory; frozen in DISCARD
  logic               reqQ;
  logic [INSTR_W-1:0] bufQ;      // parked instruction; meaningful only in HOLD

  logic               transfer;
  logic [ADDR_W-1:0]  pcPlus4;
  logic               ifIdWe;
  logic               ifIdFlush;
  logic [INSTR_W-1:0] ifIdInstr;

  assign transfer = reqQ & imem_ready_i;
  assign pcPlus4  = pcQ + ADDR_W'(PC_INCR);   // wraps modulo 2^ADDR_W

  // IF/ID control: redirect flushes; otherwise load on transfer or buffer drain,
  // bubble when decode advances with nothing to give it.
  always_comb begin
    ifIdWe    = 1'b0;
    ifIdFlush = 1'b0;
    ifIdInstr = imem_rdata_i;
    if (branch_taken_i) begin
      ifIdFlush = 1'b1;
    end else begin
      case (state)
        REQ: begin
          if (transfer) begin
            ifIdWe = hazard_we_i;
          end else begin
            ifIdFlush = hazard_we_i;
          end
        end
        HOLD: begin
          ifIdWe    = hazard_we_i;
          ifIdInstr = bufQ;
        end
        DISCARD: begin
          ifIdFlush = hazard_we_i;
        end
        default: begin
          ifIdFlush = hazard_we_i;
        end
      endcase
    end
  end

  // Fetch FSM with PC, request, address and buffer as registered outputs.
  // reqQ resets low so no request is visible while reset is held; it rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= REQ;
      pcQ   <= RESET_PC;
      addrQ <= RESET_PC;
      reqQ  <= 1'b0;
      bufQ  <= INSTR_W'(NOP_INSTR);
    end else begin
      case (state)
        REQ: begin
          if (branch_taken_i) begin
            pcQ  <= branch_target_i;
            bufQ <= INSTR_W'(NOP_INSTR);
            reqQ <= 1'b1;
            if (reqQ && !imem_ready_i) begin
              // Request in flight: keep the address stable and wait it out.
              state <= DISCARD;
            end else begin
              addrQ <= branch_target_i;
            end
          end else if (transfer) begin
            if (hazard_we_i) begin
              pcQ   <= pcPlus4;
              addrQ <= pcPlus4;
            end else begin
              bufQ  <= imem_rdata_i;
              reqQ  <= 1'b0;
              state <= HOLD;
            end
          end else begin
            reqQ <= 1'b1;
          end
        end

        HOLD: begin
          if (branch_taken_i) begin
            pcQ   <= branch_target_i;
            addrQ <= branch_target_i;
            bufQ  <= INSTR_W'(NOP_INSTR);
            reqQ  <= 1'b1;
            state <= REQ;
          end else if (hazard_we_i) begin
            pcQ   <= pcPlus4;
            addrQ <= pcPlus4;
            reqQ  <= 1'b1;
            state <= REQ;
          end
        end

        DISCARD: begin
          // pcQ holds the latest redirect target; addrQ holds the stale address.
          if (branch_taken_i) begin
            pcQ  <= branch_target_i;
            bufQ <= INSTR_W'(NOP_INSTR);
          end
          if (transfer) begin
            addrQ <= branch_target_i & {ADDR_W{branch_taken_i}} |
                     pcQ & {ADDR_W{!branch_taken_i}};
            state <= REQ;
          end
        end

        default: begin
          state <= REQ;
          reqQ  <= 1'b1;
          addrQ <= pcQ;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) uIfId (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (ifIdWe),
    .flush  (ifIdFlush),
    .instrIn(ifIdInstr),
    .pc4In  (pcPlus4),
    .instrQ (if_id_instr_o),
    .pc4Q   (if_id_pc4_o),
    .validQ (if_id_valid_o)
  );

  assign imem_req_o  = reqQ;
  assign imem_addr_o = addrQ;
  assign pc_o        = pcQ;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed vector table, hand sequences, random run.
// Latency: checks outputs one cycle after each applied input set.
// Backpressure: exercises stalls, variable memory ready and redirects.
module tb_fetch_stall_ctrl;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hazard_we_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic [AW-1:0] branch_target_i = '0;
  logic          imem_ready_i = 1'b0;
  logic [IW-1:0] imem_rdata_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic [AW-1:0] pc_o;
  logic [IW-1:0] if_id_instr_o;
  logic [AW-1:0] if_id_pc4_o;
  logic          if_id_valid_o;

  int total = 0;
  int bad   = 0;

  fetch_stall_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hazard_we_i    (hazard_we_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_rdata_i   (imem_rdata_i),
    .pc_o           (pc_o),
    .if_id_instr_o  (if_id_instr_o),
    .if_id_pc4_o    (if_id_pc4_o),
    .if_id_valid_o  (if_id_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        eReq;
    logic [31:0] eAddr;
    logic [31:0] ePc;
    logic        eValid;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
  } vec_t;

  vec_t vecs[14];

  // Reference model: a fetch pointer, the address of the one outstanding
  // request, a "stale fetch pending" flag and a queue acting as the buffer.
  logic [31:0] mPc, mAddr, mInstr, mPc4;
  logic        mReq, mDiscard, mValid;
  logic [31:0] mBuf[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 0; mAddr = 0; mReq = 0; mDiscard = 0;
    mInstr = 0; mPc4 = 0; mValid = 0;
    mBuf.delete();
  endtask

  task automatic modelStep(input logic we, input logic br, input logic [31:0] tgt, input logic rdy);
    logic        xfer;
    logic [31:0] rd;
    xfer = mReq && rdy;
    rd   = memf(mAddr);
    if (br) begin
      mValid = 0; mInstr = 0;
      mBuf.delete();
      mPc = tgt;
      if (mReq && !rdy) begin
        mDiscard = 1;
      end else begin
        mDiscard = 0; mReq = 1; mAddr = tgt;
      end
    end else if (mDiscard) begin
      if (we) begin mValid = 0; mInstr = 0; end
      if (xfer) begin mDiscard = 0; mAddr = mPc; end
    end else if (mBuf.size() > 0) begin
      if (we) begin
        mInstr = mBuf.pop_front();
        mPc4 = mPc + 4; mValid = 1;
        mPc = mPc + 4; mReq = 1; mAddr = mPc;
      end
    end else if (xfer) begin
      if (we) begin
        mInstr = rd; mPc4 = mPc + 4; mValid = 1;
        mPc = mPc + 4; mAddr = mPc;
      end else begin
        mBuf.push_back(rd);
        mReq = 0;
      end
    end else begin
      if (we) begin mValid = 0; mInstr = 0; end
      mReq = 1; mAddr = mPc;
    end
  endtask

  // Called just after a falling edge; applies inputs for one rising edge
  // and returns at the next falling edge.
  task automatic drive(input logic we, input logic br, input logic [31:0] tgt, input logic rdy);
    hazard_we_i     = we;
    branch_taken_i  = br;
    branch_target_i = tgt;
    imem_ready_i    = rdy;
    imem_rdata_i    = rdy ? memf(imem_addr_o) : 32'hDEAD_BEEF;
    modelStep(we, br, tgt, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chkModel(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, mReq});
    chk({tag, "_pc"}, pc_o, mPc);
    chk({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, mValid});
    chk({tag, "_instr"}, if_id_instr_o, mInstr);
    if (mReq) chk({tag, "_addr"}, imem_addr_o, mAddr);
    if (mValid) chk({tag, "_pc4"}, if_id_pc4_o, mPc4);
  endtask

  task automatic doReset();
    reset_n = 0;
    hazard_we_i = 0; branch_taken_i = 0; branch_target_i = '0;
    imem_ready_i = 0; imem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("rst_instr", if_id_instr_o, 32'd0);
    chk("rst_pc4", if_id_pc4_o, 32'd0);
    reset_n = 1;
    modelReset();
  endtask

  initial begin
    //        we  br  tgt       rdy req addr     pc       valid instr          pc4
    vecs[0]  = '{1, 0, 32'h0,  1, 1, 32'h0,  32'h0,  0, 32'h0,        32'h0};
    vecs[1]  = '{1, 0, 32'h0,  1, 1, 32'h4,  32'h4,  1, memf(32'h0),  32'h4};
    vecs[2]  = '{1, 0, 32'h0,  1, 1, 32'h8,  32'h8,  1, memf(32'h4),  32'h8};
    vecs[3]  = '{0, 0, 32'h0,  1, 0, 32'h8,  32'h8,  1, memf(32'h4),  32'h8};
    vecs[4]  = '{0, 0, 32'h0,  1, 0, 32'h8,  32'h8,  1, memf(32'h4),  32'h8};
    vecs[5]  = '{1, 0, 32'h0,  1, 1, 32'hC,  32'hC,  1, memf(32'h8),  32'hC};
    vecs[6]  = '{1, 0, 32'h0,  1, 1, 32'h10, 32'h10, 1, memf(32'hC),  32'h10};
    vecs[7]  = '{1, 1, 32'h40, 0, 1, 32'h10, 32'h40, 0, 32'h0,        32'h0};
    vecs[8]  = '{1, 0, 32'h0,  0, 1, 32'h10, 32'h40, 0, 32'h0,        32'h0};
    vecs[9]  = '{1, 0, 32'h0,  1, 1, 32'h40, 32'h40, 0, 32'h0,        32'h0};
    vecs[10] = '{1, 0, 32'h0,  1, 1, 32'h44, 32'h44, 1, memf(32'h40), 32'h44};
    vecs[11] = '{0, 0, 32'h0,  1, 0, 32'h44, 32'h44, 1, memf(32'h40), 32'h44};
    vecs[12] = '{0, 1, 32'h80, 1, 1, 32'h80, 32'h80, 0, 32'h0,        32'h0};
    vecs[13] = '{1, 0, 32'h0,  1, 1, 32'h84, 32'h84, 1, memf(32'h80), 32'h84};

    @(negedge clk);
    doReset();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req_o}, {31'd0, vecs[i].eReq});
      if (vecs[i].eReq) chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].eAddr);
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].ePc);
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid_o}, {31'd0, vecs[i].eValid});
      chk($sformatf("v%0d_instr", i), if_id_instr_o, vecs[i].eInstr);
      if (vecs[i].eValid) chk($sformatf("v%0d_pc4", i), if_id_pc4_o, vecs[i].ePc4);
    end

    // PC wrap at the top of the address space.
    drive(1, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 1);
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_pc4", if_id_pc4_o, 32'h0);
    chk("wrap_valid", {31'd0, if_id_valid_o}, 32'd1);
    chk("wrap_instr", if_id_instr_o, memf(32'hFFFF_FFFC));

    // Async reset while waiting out a stale fetch.
    drive(1, 1, 32'h200, 0);
    chk("disc_req", {31'd0, imem_req_o}, 32'd1);
    chk("disc_addr", imem_addr_o, 32'h0);
    chk("disc_pc", pc_o, 32'h200);
    #2 reset_n = 0;
    #1;
    chk("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_valid", {31'd0, if_id_valid_o}, 32'd0);
    chk("arst_instr", if_id_instr_o, 32'h0);
    @(negedge clk);
    reset_n = 1;
    modelReset();
    drive(1, 0, 32'h0, 1);
    chk("post_req", {31'd0, imem_req_o}, 32'd1);
    chk("post_addr", imem_addr_o, 32'h0);
    chk("post_valid", {31'd0, if_id_valid_o}, 32'd0);
    drive(1, 0, 32'h0, 1);
    chk("post_instr", if_id_instr_o, memf(32'h0));
    chk("post_pc4", if_id_pc4_o, 32'h4);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic        we, br, rdy;
      logic [31:0] tgt;
      we  = ($urandom_range(99) < 75);
      br  = ($urandom_range(99) < 10);
      rdy = ($urandom_range(99) < 65);
      tgt = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      drive(we, br, tgt, rdy);
      chkModel($sformatf("r%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
